// File: rtl/isp_dram_if.sv
// Command, DRAM (AXI4-style) and datapath signals of the ISP DRAM scheduler.
// The master modport is the scheduler's view; slave is its environment.
interface isp_dram_if;
  logic        in_valid;
  logic [3:0]  in_pic_no;
  logic        in_mode;
  logic [1:0]  in_ratio_mode;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid;
  logic        r_last;
  logic        r_ready;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic        w_valid;
  logic        w_ready;
  logic        w_last;
  logic        b_valid;
  logic        b_ready;
  logic        dp_start;
  logic        dp_mode;
  logic [1:0]  dp_ratio;
  logic [1:0]  dp_chan;
  logic        dp_rbeat;
  logic        dp_wvalid;
  logic        dp_wready;
  logic        dp_done;
  logic [7:0]  dp_result;

  modport master (
    input  in_valid, in_pic_no, in_mode, in_ratio_mode,
    input  ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid,
    input  dp_wvalid, dp_done, dp_result,
    output out_valid, out_data,
    output ar_valid, ar_addr, ar_len, r_ready,
    output aw_valid, aw_addr, aw_len, w_valid, w_last, b_ready,
    output dp_start, dp_mode, dp_ratio, dp_chan, dp_rbeat, dp_wready
  );

  modport slave (
    output in_valid, in_pic_no, in_mode, in_ratio_mode,
    output ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid,
    output dp_wvalid, dp_done, dp_result,
    input  out_valid, out_data,
    input  ar_valid, ar_addr, ar_len, r_ready,
    input  aw_valid, aw_addr, aw_len, w_valid, w_last, b_ready,
    input  dp_start, dp_mode, dp_ratio, dp_chan, dp_rbeat, dp_wready
  );
endinterface

// File: rtl/isp_dram_scheduler.sv
// Command-level ISP controller: focus-window reads, exposure read-modify-write
// chunks, datapath handshake and a per-picture focus-result cache.
module isp_dram_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  isp_dram_if.master  bus
);
  localparam logic [31:0] DRAM_BASE   = 32'h0001_0000;
  localparam int unsigned PIC_BYTES   = 3072;
  localparam int unsigned CH_BYTES    = 1024;
  localparam int unsigned FOCUS_OFS   = 416;
  localparam int unsigned FOCUS_BEATS = 12;
  localparam int unsigned CHUNK_BEATS = 16;
  localparam int unsigned NUM_CHUNKS  = 12;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_AR, S_R, S_AW, S_W, S_B, S_WAIT_DP, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pic_q, pic_d;
  logic             mode_q, mode_d;
  logic [1:0]       ratio_q, ratio_d;
  logic [1:0]       chan_q, chan_d;
  logic [3:0]       chunk_q, chunk_d;
  logic [7:0]       beat_q, beat_d;
  logic [15:0]      cache_vld_q, cache_vld_d;
  logic [15:0][1:0] cache_val_q, cache_val_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;

  logic        cache_hit;
  logic [31:0] pic_base;
  logic [31:0] burst_addr;
  logic [7:0]  burst_len;
  logic        in_w;
  logic        w_hs;

  // Focus bursts walk channels; exposure bursts walk 256-byte chunks.
  assign cache_hit  = ~mode_q & cache_vld_q[pic_q];
  assign pic_base   = DRAM_BASE + 32'(pic_q) * PIC_BYTES;
  assign burst_addr = mode_q ? pic_base + 32'(chunk_q) * (CHUNK_BEATS * 16)
                             : pic_base + 32'(chan_q) * CH_BYTES + FOCUS_OFS;
  assign burst_len  = mode_q ? 8'(CHUNK_BEATS - 1) : 8'(FOCUS_BEATS - 1);
  assign in_w       = (state_q == S_W);
  assign w_hs       = in_w & bus.dp_wvalid & bus.w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pic_q       <= '0;
      mode_q      <= 1'b0;
      ratio_q     <= '0;
      chan_q      <= '0;
      chunk_q     <= '0;
      beat_q      <= '0;
      cache_vld_q <= '0;
      cache_val_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pic_q       <= pic_d;
      mode_q      <= mode_d;
      ratio_q     <= ratio_d;
      chan_q      <= chan_d;
      chunk_q     <= chunk_d;
      beat_q      <= beat_d;
      cache_vld_q <= cache_vld_d;
      cache_val_q <= cache_val_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pic_d        = pic_q;
    mode_d       = mode_q;
    ratio_d      = ratio_q;
    chan_d       = chan_q;
    chunk_d      = chunk_q;
    beat_d       = beat_q;
    cache_vld_d  = cache_vld_q;
    cache_val_d  = cache_val_q;
    out_valid_d  = 1'b0;
    out_data_d   = '0;
    bus.dp_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          pic_d   = bus.in_pic_no;
          mode_d  = bus.in_mode;
          ratio_d = bus.in_ratio_mode;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        chan_d  = '0;
        chunk_d = '0;
        beat_d  = '0;
        if (cache_hit) begin
          out_valid_d = 1'b1;
          out_data_d  = {6'b0, cache_val_q[pic_q]};
          state_d     = S_RESP;
        end else begin
          bus.dp_start = 1'b1;
          state_d      = S_AR;
          // Any rescaling exposure changes the pixels a cached focus value was computed from.
          if (mode_q && ratio_q != 2'd2) cache_vld_d[pic_q] = 1'b0;
        end
      end
      S_AR: if (bus.ar_ready) state_d = S_R;
      S_R: begin
        if (bus.r_valid && bus.r_last) begin
          if (mode_q) begin
            state_d = S_AW;
          end else begin
            chan_d  = chan_q + 2'd1;
            state_d = (chan_q == 2'd2) ? S_WAIT_DP : S_AR;
          end
        end
      end
      S_AW: if (bus.aw_ready) state_d = S_W;
      S_W: begin
        if (w_hs) begin
          if (beat_q == 8'(CHUNK_BEATS - 1)) begin
            beat_d  = '0;
            state_d = S_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_B: begin
        if (bus.b_valid) begin
          chunk_d = chunk_q + 4'd1;
          state_d = (chunk_q == 4'(NUM_CHUNKS - 1)) ? S_WAIT_DP : S_AR;
        end
      end
      S_WAIT_DP: begin
        if (bus.dp_done) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.dp_result;
          state_d     = S_RESP;
          if (!mode_q) begin
            cache_vld_d[pic_q] = 1'b1;
            cache_val_d[pic_q] = bus.dp_result[1:0];
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode the state register only, except the pass-through beat strobes.
  assign bus.ar_valid  = (state_q == S_AR);
  assign bus.ar_addr   = bus.ar_valid ? burst_addr : '0;
  assign bus.ar_len    = bus.ar_valid ? burst_len : '0;
  assign bus.r_ready   = (state_q == S_R);
  assign bus.dp_rbeat  = bus.r_valid & bus.r_ready;
  assign bus.aw_valid  = (state_q == S_AW);
  assign bus.aw_addr   = bus.aw_valid ? burst_addr : '0;
  assign bus.aw_len    = bus.aw_valid ? 8'(CHUNK_BEATS - 1) : '0;
  assign bus.w_valid   = in_w & bus.dp_wvalid;
  assign bus.dp_wready = in_w & bus.w_ready;
  assign bus.w_last    = in_w & (beat_q == 8'(CHUNK_BEATS - 1));
  assign bus.b_ready   = (state_q == S_B);
  assign bus.dp_mode   = mode_q;
  assign bus.dp_ratio  = ratio_q;
  assign bus.dp_chan   = chan_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_isp_dram_scheduler.sv
// Randomized bench for isp_dram_scheduler: AXI/datapath responders plus a
// transaction-level model of expected bursts, results and cache contents.
module tb_isp_dram_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  isp_dram_if bus ();

  isp_dram_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] focus_addr(input int pic, input int ch);
    return 32'h0001_0000 + 32'(pic * 3072 + ch * 1024 + 416);
  endfunction

  function automatic logic [31:0] chunk_addr(input int pic, input int n);
    return 32'h0001_0000 + 32'(pic * 3072 + n * 256);
  endfunction

  // Model state (written only by the monitor)
  bit          busy, armed, cur_mode, exp_dp_start, prev_ar_wait;
  int          cur_pic, out_cnt, reads_done, b_done, wbeat;
  logic [7:0]  out_exp, last_out;
  bit          m_vld [16];
  int          m_val [16];
  logic [31:0] exp_ar_addr [$];
  int          exp_ar_len  [$];
  logic [31:0] exp_aw_addr [$];
  logic [31:0] prev_ar_addr;
  bit          f_ar_hs, f_r_hs, f_wlast_hs, f_b_hs;
  int          f_ar_len;
  int          ar_hs_total, aw_hs_total, w_hs_total, lat_cnt, last_lat;
  int          ar_wait_run, ar_wait_max;

  // Responder state (driver) and directed knobs (main)
  int cyc, rd_left, stall_end, dp_fix;
  bit b_pend;

  // Compare process: every negedge, DUT outputs against the model.
  initial begin : mon
    bit ev;
    forever begin
      @(negedge clk);
      f_ar_hs = 0; f_r_hs = 0; f_wlast_hs = 0; f_b_hs = 0;
      if (!rst_n) begin
        chk(!bus.ar_valid && !bus.aw_valid && !bus.w_valid && !bus.out_valid && bus.out_data == 8'h0,
            "reset_quiet", 64'({bus.ar_valid, bus.aw_valid, bus.w_valid, bus.out_valid, bus.out_data}), 64'h0);
        busy = 0; armed = 0; out_cnt = 0; exp_dp_start = 0; prev_ar_wait = 0;
        reads_done = 0; b_done = 0; wbeat = 0; ar_wait_run = 0;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_aw_addr.delete();
        for (int i = 0; i < 16; i++) m_vld[i] = 0;
        continue;
      end
      lat_cnt++;
      ev = 0;
      if (out_cnt > 0) begin
        out_cnt--;
        ev = (out_cnt == 0);
      end
      if (ev) begin
        chk(bus.out_valid == 1'b1, "out_valid", 64'(bus.out_valid), 64'h1);
        chk(bus.out_data == out_exp, "out_data", 64'(bus.out_data), 64'(out_exp));
        busy = 0; last_out = bus.out_data; last_lat = lat_cnt;
      end else begin
        chk(bus.out_valid == 1'b0 && bus.out_data == 8'h0, "out_idle",
            64'({bus.out_valid, bus.out_data}), 64'h0);
      end
      chk(bus.dp_start == exp_dp_start, "dp_start", 64'(bus.dp_start), 64'(exp_dp_start));
      exp_dp_start = 0;
      chk(bus.dp_rbeat == (bus.r_valid && bus.r_ready), "dp_rbeat", 64'(bus.dp_rbeat),
          64'(bus.r_valid && bus.r_ready));
      // A result only counts once every burst of the command has completed.
      if (armed && bus.dp_done) begin
        armed = 0; out_cnt = 1; out_exp = bus.dp_result;
        if (!cur_mode) begin
          m_vld[cur_pic] = 1;
          m_val[cur_pic] = int'(bus.dp_result[1:0]);
        end
      end
      if (bus.ar_valid) begin
        if (exp_ar_addr.size() == 0) begin
          chk(0, "ar_unexpected", 64'(bus.ar_addr), 64'h0);
        end else begin
          chk(bus.ar_addr == exp_ar_addr[0], "ar_addr", 64'(bus.ar_addr), 64'(exp_ar_addr[0]));
          chk(bus.ar_len == 8'(exp_ar_len[0]), "ar_len", 64'(bus.ar_len), 64'(exp_ar_len[0]));
        end
        chk(64'(bus.ar_addr) + 64'(bus.ar_len) * 16 + 16 <= 64'h1_C000, "ar_range",
            64'(bus.ar_addr), 64'h1_C000);
        if (prev_ar_wait)
          chk(bus.ar_addr == prev_ar_addr, "ar_stable", 64'(bus.ar_addr), 64'(prev_ar_addr));
        if (bus.ar_ready) begin
          if (exp_ar_addr.size() > 0) begin
            void'(exp_ar_addr.pop_front());
            void'(exp_ar_len.pop_front());
          end
          f_ar_hs = 1; f_ar_len = int'(bus.ar_len); ar_hs_total++;
        end
      end
      prev_ar_wait = bus.ar_valid && !bus.ar_ready;
      prev_ar_addr = bus.ar_addr;
      ar_wait_run  = prev_ar_wait ? ar_wait_run + 1 : 0;
      if (ar_wait_run > ar_wait_max) ar_wait_max = ar_wait_run;
      if (bus.aw_valid) begin
        if (exp_aw_addr.size() == 0) begin
          chk(0, "aw_unexpected", 64'(bus.aw_addr), 64'h0);
        end else begin
          chk(bus.aw_addr == exp_aw_addr[0], "aw_addr", 64'(bus.aw_addr), 64'(exp_aw_addr[0]));
          chk(bus.aw_len == 8'd15, "aw_len", 64'(bus.aw_len), 64'd15);
        end
        if (bus.aw_ready) begin
          if (exp_aw_addr.size() > 0) void'(exp_aw_addr.pop_front());
          aw_hs_total++;
        end
      end
      if (bus.r_valid && bus.r_ready) begin
        f_r_hs = 1;
        if (bus.r_last && !cur_mode) begin
          reads_done++;
          if (reads_done == 3) armed = 1;
        end
      end
      if (bus.w_valid && bus.w_ready) begin
        chk(bus.w_last == (wbeat == 15), "w_last", 64'(bus.w_last), 64'(wbeat == 15));
        f_wlast_hs = (wbeat == 15);
        wbeat = (wbeat + 1) % 16;
        w_hs_total++;
      end
      if (bus.b_valid && bus.b_ready) begin
        f_b_hs = 1; b_done++;
        if (b_done == 12 && cur_mode) armed = 1;
      end
      if (bus.in_valid && !busy) begin
        busy = 1; lat_cnt = 0; reads_done = 0; b_done = 0; wbeat = 0;
        cur_pic = int'(bus.in_pic_no); cur_mode = bus.in_mode;
        if (!cur_mode && m_vld[cur_pic]) begin
          out_cnt = 2; out_exp = 8'(m_val[cur_pic]);
        end else begin
          exp_dp_start = 1;
          if (!cur_mode) begin
            for (int ch = 0; ch < 3; ch++) begin
              exp_ar_addr.push_back(focus_addr(cur_pic, ch));
              exp_ar_len.push_back(11);
            end
          end else begin
            for (int n = 0; n < 12; n++) begin
              exp_ar_addr.push_back(chunk_addr(cur_pic, n));
              exp_ar_len.push_back(15);
              exp_aw_addr.push_back(chunk_addr(cur_pic, n));
            end
            if (bus.in_ratio_mode != 2'd2) m_vld[cur_pic] = 0;
          end
        end
      end
    end
  end

  // DRAM slave and datapath responders with random back-pressure.
  initial begin : drv
    bus.ar_ready = 0; bus.r_valid = 0; bus.r_last = 0; bus.aw_ready = 0;
    bus.w_ready = 0; bus.b_valid = 0; bus.dp_wvalid = 0; bus.dp_done = 0; bus.dp_result = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        rd_left = 0; b_pend = 0;
      end else begin
        if (f_r_hs && rd_left > 0) rd_left--;
        if (f_ar_hs) rd_left = f_ar_len + 1;
        if (f_wlast_hs) b_pend = 1;
        if (f_b_hs) b_pend = 0;
      end
      bus.ar_ready  = (cyc >= stall_end) && ($urandom_range(0, 3) != 0);
      bus.r_valid   = (rd_left > 0) && ($urandom_range(0, 3) != 0);
      bus.r_last    = bus.r_valid && (rd_left == 1);
      bus.aw_ready  = ($urandom_range(0, 3) != 0);
      bus.w_ready   = 1'($urandom_range(0, 1));
      bus.dp_wvalid = ($urandom_range(0, 3) != 0);
      bus.b_valid   = b_pend && ($urandom_range(0, 2) != 0);
      bus.dp_done   = ($urandom_range(0, 3) == 0);
      bus.dp_result = (dp_fix >= 0) ? 8'(dp_fix) : 8'($urandom_range(0, 255));
    end
  end

  task automatic issue(input int pic, input int mode, input int ratio, input int hold);
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_pic_no = 4'(pic); bus.in_mode = 1'(mode); bus.in_ratio_mode = 2'(ratio);
    repeat (hold) begin @(posedge clk); #1; end
    bus.in_valid = 0;
  endtask

  task automatic run_cmd(input int pic, input int mode, input int ratio, input int hold);
    int n;
    issue(pic, mode, ratio, hold);
    n = 0;
    while (busy && n < 6000) begin @(posedge clk); n++; end
    chk(n < 6000, "cmd_timeout", 64'(n), 64'd6000);
  endtask

  initial begin : main
    int a0, aw0, w0, n;
    rst_n = 0; dp_fix = 2; stall_end = 0;
    bus.in_valid = 0; bus.in_pic_no = 0; bus.in_mode = 0; bus.in_ratio_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #84;
    chk(bus.out_valid == 1'b0, "rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk(bus.out_data == 8'h0, "rst_out_data", 64'(bus.out_data), 64'h0);
    chk(!bus.ar_valid && !bus.aw_valid && !bus.w_valid, "rst_valids",
        64'({bus.ar_valid, bus.aw_valid, bus.w_valid}), 64'h0);
    // Picture 3 base = 0x10000 + 3*3072 = 0x12400; focus rows start 0x1A0 into each 0x400 channel.
    chk(focus_addr(3, 0) == 32'h0001_25A0, "model_focus0", 64'(focus_addr(3, 0)), 64'h125A0);
    chk(focus_addr(3, 2) == 32'h0001_2DA0, "model_focus2", 64'(focus_addr(3, 2)), 64'h12DA0);
    chk(chunk_addr(3, 11) == 32'h0001_2F00, "model_chunk11", 64'(chunk_addr(3, 11)), 64'h12F00);

    a0 = ar_hs_total;
    run_cmd(3, 0, 0, 1);
    chk(ar_hs_total - a0 == 3, "cold_focus_reads", 64'(ar_hs_total - a0), 64'd3);
    chk(last_out == 8'd2, "cold_focus_result", 64'(last_out), 64'd2);

    a0 = ar_hs_total;
    run_cmd(3, 0, 1, 2);
    chk(ar_hs_total - a0 == 0, "hit_no_reads", 64'(ar_hs_total - a0), 64'd0);
    chk(last_out == 8'd2, "hit_result", 64'(last_out), 64'd2);
    chk(last_lat == 2, "hit_latency", 64'(last_lat), 64'd2);

    dp_fix = 8'h5A;
    a0 = ar_hs_total; aw0 = aw_hs_total; w0 = w_hs_total;
    run_cmd(3, 1, 0, 1);
    chk(ar_hs_total - a0 == 12, "expo_reads", 64'(ar_hs_total - a0), 64'd12);
    chk(aw_hs_total - aw0 == 12, "expo_writes", 64'(aw_hs_total - aw0), 64'd12);
    chk(w_hs_total - w0 == 192, "expo_beats", 64'(w_hs_total - w0), 64'd192);
    chk(last_out == 8'h5A, "expo_result", 64'(last_out), 64'h5A);
    dp_fix = 1;
    a0 = ar_hs_total;
    run_cmd(3, 0, 0, 1);
    chk(ar_hs_total - a0 == 3, "invalidated_reads", 64'(ar_hs_total - a0), 64'd3);

    dp_fix = 2;
    run_cmd(5, 0, 0, 1);
    dp_fix = 8'h33;
    run_cmd(5, 1, 2, 1);
    a0 = ar_hs_total;
    run_cmd(5, 0, 0, 1);
    chk(ar_hs_total - a0 == 0, "kept_cache_hit", 64'(ar_hs_total - a0), 64'd0);
    chk(last_out == 8'd2, "kept_cache_result", 64'(last_out), 64'd2);

    // Long AR stall, then reset in the middle of the first write chunk.
    stall_end = cyc + 22;
    w0 = w_hs_total;
    issue(1, 1, 3, 1);
    n = 0;
    while (w_hs_total == w0 && n < 3000) begin @(posedge clk); n++; end
    chk(n < 3000, "reach_w_timeout", 64'(n), 64'd3000);
    chk(ar_wait_max >= 15, "ar_stall_held", 64'(ar_wait_max), 64'd15);
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk(!bus.ar_valid && !bus.aw_valid && !bus.w_valid && !bus.out_valid, "post_reset_idle",
        64'({bus.ar_valid, bus.aw_valid, bus.w_valid, bus.out_valid}), 64'h0);
    dp_fix = 0;
    a0 = ar_hs_total;
    run_cmd(3, 0, 0, 1);
    chk(ar_hs_total - a0 == 3, "cache_cleared_reads", 64'(ar_hs_total - a0), 64'd3);

    dp_fix = -1;
    for (int i = 0; i < 30; i++)
      run_cmd(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 1 : 0,
              int'($urandom_range(0, 3)), int'($urandom_range(1, 2)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
